// File: rtl/rx_serie_paralelo_if.sv
// Serial lane bundle between a parallel-to-serial transmitter and the rx_serie_paralelo receiver.
// master: the side that drives the serial bit and consumes recovered bytes; slave: the receiver.
interface rx_serie_paralelo_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );
endinterface

// File: rtl/rx_serie_paralelo.sv
// Serial-to-parallel lane receiver: comma hunt, lock after LOCK_COUNT aligned commas, payload delivery.
// Optional byte-period watchdog that drops lock after WDT_BYTES non-comma bytes: macro RX_BC_WATCHDOG_EN.
module rx_serie_paralelo #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4
`ifdef RX_BC_WATCHDOG_EN
    ,
    parameter int         WDT_BYTES  = 64
`endif
) (
    input  logic               clk_8f,
    input  logic               reset,
    rx_serie_paralelo_if.slave bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam int BC_W = $clog2(LOCK_COUNT + 1);
`ifdef RX_BC_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_BYTES + 1);
`endif

    // Only seven bits of history feed the candidate byte; the eighth is the live input.
    logic [6:0]      sr_r;
    logic [2:0]      bit_cnt_r;
    logic [BC_W-1:0] bc_cnt_r;
    state_t          state_r;
    logic [7:0]      data_r;
    logic            valid_r;
    logic            active_r;
`ifdef RX_BC_WATCHDOG_EN
    logic [WDT_W-1:0] wdt_cnt_r;
`endif

    logic [7:0] nb_s;
    logic       comma_s;
    logic       boundary_s;

    assign nb_s       = {sr_r, bus.data_in};
    assign comma_s    = (nb_s == COMMA);
    assign boundary_s = (bit_cnt_r == 3'd7);

    assign bus.data_out  = data_r;
    assign bus.valid_out = valid_r;
    assign bus.active    = active_r;

    // Shift register, alignment FSM and registered outputs.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            sr_r      <= 7'd0;
            bit_cnt_r <= 3'd0;
            bc_cnt_r  <= {BC_W{1'b0}};
            state_r   <= SEARCH;
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            active_r  <= 1'b0;
`ifdef RX_BC_WATCHDOG_EN
            wdt_cnt_r <= {WDT_W{1'b0}};
`endif
        end else begin
            sr_r <= nb_s[6:0];
            case (state_r)
                SEARCH: begin
                    bit_cnt_r <= 3'd0;
                    if (comma_s) begin
                        bc_cnt_r <= BC_W'(1);
                        state_r  <= ALIGN;
                    end else begin
                        bc_cnt_r <= {BC_W{1'b0}};
                        state_r  <= SEARCH;
                    end
                end

                ALIGN: begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (boundary_s) begin
                        if (comma_s) begin
                            bc_cnt_r <= bc_cnt_r + BC_W'(1);
                            if (bc_cnt_r == BC_W'(LOCK_COUNT - 1)) begin
                                state_r  <= ACTIVE;
                                active_r <= 1'b1;
`ifdef RX_BC_WATCHDOG_EN
                                wdt_cnt_r <= {WDT_W{1'b0}};
`endif
                            end else begin
                                state_r <= ALIGN;
                            end
                        end else begin
                            bc_cnt_r <= {BC_W{1'b0}};
                            state_r  <= SEARCH;
                        end
                    end else begin
                        state_r <= ALIGN;
                    end
                end

                ACTIVE: begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (boundary_s) begin
                        if (comma_s) begin
                            // Idle byte: drop valid, keep the last payload on data_out.
                            valid_r <= 1'b0;
`ifdef RX_BC_WATCHDOG_EN
                            wdt_cnt_r <= {WDT_W{1'b0}};
`endif
                        end
`ifdef RX_BC_WATCHDOG_EN
                        else if (wdt_cnt_r == WDT_W'(WDT_BYTES - 1)) begin
                            state_r   <= SEARCH;
                            active_r  <= 1'b0;
                            valid_r   <= 1'b0;
                            data_r    <= 8'h00;
                            bc_cnt_r  <= {BC_W{1'b0}};
                            wdt_cnt_r <= {WDT_W{1'b0}};
                        end
`endif
                        else begin
                            data_r  <= nb_s;
                            valid_r <= 1'b1;
`ifdef RX_BC_WATCHDOG_EN
                            wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
`endif
                        end
                    end else begin
                        state_r <= ACTIVE;
                    end
                end

                default: begin
                    bit_cnt_r <= 3'd0;
                    bc_cnt_r  <= {BC_W{1'b0}};
                    state_r   <= SEARCH;
                    data_r    <= 8'h00;
                    valid_r   <= 1'b0;
                    active_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_serie_paralelo.sv
// Directed bench for rx_serie_paralelo: reset, lock at offset, idle/data mix, broken alignment,
// mid-ACTIVE reset and the watchdog (expectations switch on RX_BC_WATCHDOG_EN).
module tb_rx_serie_paralelo;
    logic clk_8f = 1'b0;
    logic reset  = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    rx_serie_paralelo_if bus ();

`ifdef RX_BC_WATCHDOG_EN
    rx_serie_paralelo #(.COMMA(8'hBC), .LOCK_COUNT(4), .WDT_BYTES(4)) dut (
        .clk_8f(clk_8f),
        .reset (reset),
        .bus   (bus)
    );
`else
    rx_serie_paralelo #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
        .clk_8f(clk_8f),
        .reset (reset),
        .bus   (bus)
    );
`endif

    always #5 clk_8f = ~clk_8f;

    task automatic check(input string tag, input logic [7:0] ed, input logic ev, input logic ea);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {bus.data_out, bus.valid_out, bus.active};
        exp = {ed, ev, ea};
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed data=%h valid=%b active=%b, expected data=%h valid=%b active=%b",
                   tag, obs[9:2], obs[1], obs[0], ed, ev, ea);
        end
    endtask

    // Present one bit (and reset level) before the rising edge, return 1 time unit after it.
    task automatic send_bit(input logic b, input logic r);
        @(negedge clk_8f);
        bus.data_in = b;
        reset       = r;
        @(posedge clk_8f);
        #1;
    endtask

    // Send a byte MSB first; outputs must hold (hd,hv,ha) for 7 bits, then show (ed,ev,ea).
    task automatic send_byte(input string tag, input logic [7:0] b,
                             input logic [7:0] hd, input logic hv, input logic ha,
                             input logic [7:0] ed, input logic ev, input logic ea);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], 1'b0);
            if (i != 0) check({tag, "_hold"}, hd, hv, ha);
            else        check(tag, ed, ev, ea);
        end
    endtask

    initial begin
        bus.data_in = 1'b0;

        // Reset held 3 cycles with random data
        for (int i = 0; i < 3; i++) begin
            send_bit(1'($urandom_range(0, 1)), 1'b1);
            check("reset_hold", 8'h00, 1'b0, 1'b0);
        end
        for (int i = 0; i < 100; i++) begin
            send_bit(1'b0, 1'b0);
            check("zeros_idle", 8'h00, 1'b0, 1'b0);
        end

        // Lock at bit offset 3: junk 101 then 4 commas
        send_bit(1'b1, 1'b0); check("junk0", 8'h00, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0); check("junk1", 8'h00, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0); check("junk2", 8'h00, 1'b0, 1'b0);
        send_byte("lock_bc1", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_byte("lock_bc2", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_byte("lock_bc3", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_byte("lock_bc4", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        send_byte("data_5a",  8'h5A, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1);

        // Idle/data mix while active
        send_byte("mix_00",  8'h00, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
        send_byte("mix_bc1", 8'hBC, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        send_byte("mix_ff",  8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        send_byte("mix_bc2", 8'hBC, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);

        // Reset pulse in the middle of a byte while active
        send_bit(1'b1, 1'b0); check("pre_rst0", 8'hFF, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0); check("pre_rst1", 8'hFF, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0); check("pre_rst2", 8'hFF, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1); check("mid_reset", 8'h00, 1'b0, 1'b0);

        // Broken alignment: 2 commas, 0x12, then a fresh run of 4 commas
        send_byte("brk_bc1", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_byte("brk_bc2", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_byte("brk_12",  8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_byte("run_bc1", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_byte("run_bc2", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_byte("run_bc3", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        send_byte("run_bc4", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        send_byte("data_34", 8'h34, 8'h00, 1'b0, 1'b1, 8'h34, 1'b1, 1'b1);

        // Watchdog window: one comma clears the count, then 4 payload bytes
        send_byte("wd_bc",   8'hBC, 8'h34, 1'b1, 1'b1, 8'h34, 1'b0, 1'b1);
        send_byte("wd_11",   8'h11, 8'h34, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1);
        send_byte("wd_22",   8'h22, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        send_byte("wd_33",   8'h33, 8'h22, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1);
`ifdef RX_BC_WATCHDOG_EN
        send_byte("wd_44",   8'h44, 8'h33, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        send_byte("wd_after", 8'h55, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`else
        send_byte("wd_44",   8'h44, 8'h33, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
        send_byte("wd_after", 8'h55, 8'h44, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
